// File: rtl/floo_axi_mem_responder.sv
// AXI4 subordinate backed by a word-addressed memory. Independent write and read
// engines, one burst in flight per direction, fixed read latency.
module floo_axi_mem_responder #(
    parameter int unsigned          AddrWidth   = 32,
    parameter int unsigned          DataWidth   = 64,
    parameter int unsigned          IdWidth     = 3,
    parameter logic [AddrWidth-1:0] MemBaseAddr = AddrWidth'(32'h0000_0000),
    parameter int unsigned          NumWords    = 1024,
    parameter int unsigned          ReadLatency = 2,
    parameter type axi_req_t = struct packed {
        struct packed {
            logic [IdWidth-1:0] id; logic [AddrWidth-1:0] addr; logic [7:0] len;
            logic [2:0] size; logic [1:0] burst; logic lock; logic [3:0] cache;
            logic [2:0] prot; logic [3:0] qos; logic [3:0] region; logic [5:0] atop;
            logic user;
        } aw;
        logic aw_valid;
        struct packed {
            logic [DataWidth-1:0] data; logic [DataWidth/8-1:0] strb; logic last; logic user;
        } w;
        logic w_valid;
        logic b_ready;
        struct packed {
            logic [IdWidth-1:0] id; logic [AddrWidth-1:0] addr; logic [7:0] len;
            logic [2:0] size; logic [1:0] burst; logic lock; logic [3:0] cache;
            logic [2:0] prot; logic [3:0] qos; logic [3:0] region; logic user;
        } ar;
        logic ar_valid;
        logic r_ready;
    },
    parameter type axi_rsp_t = struct packed {
        logic aw_ready;
        logic ar_ready;
        logic w_ready;
        logic b_valid;
        struct packed { logic [IdWidth-1:0] id; logic [1:0] resp; logic user; } b;
        logic r_valid;
        struct packed {
            logic [IdWidth-1:0] id; logic [DataWidth-1:0] data; logic [1:0] resp;
            logic last; logic user;
        } r;
    }
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  axi_req_t axi_req_i,
    output axi_rsp_t axi_rsp_o
);

    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned OffBits   = $clog2(StrbWidth);
    localparam int unsigned IdxBits   = (NumWords > 1) ? $clog2(NumWords) : 1;
    localparam logic [AddrWidth:0] MemBytes = (AddrWidth + 1)'(NumWords * StrbWidth);
    localparam logic [1:0] BurstFixed = 2'b00;
    localparam logic [1:0] BurstWrap  = 2'b10;
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;

    typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
    typedef enum logic [1:0] {RIdle, RWait, RData} r_state_e;

    function automatic logic addr_ok(input logic [AddrWidth-1:0] addr);
        logic [AddrWidth-1:0] off;
        off = addr - MemBaseAddr;
        return (addr >= MemBaseAddr) && ({1'b0, off} < MemBytes);
    endfunction

    function automatic logic [IdxBits-1:0] word_idx(input logic [AddrWidth-1:0] addr);
        logic [AddrWidth-1:0] off;
        off = (addr - MemBaseAddr) >> OffBits;
        return IdxBits'(off);
    endfunction

    // MSB of the result is the carry out, i.e. the address wrapped past 2^AddrWidth.
    function automatic logic [AddrWidth:0] next_addr(input logic [AddrWidth-1:0] addr,
                                                     input logic [2:0] size,
                                                     input logic [1:0] burst);
        logic [AddrWidth-1:0] step;
        step = AddrWidth'(1) << size;
        if (burst == BurstFixed) return {1'b0, addr};
        return {1'b0, addr & ~(step - AddrWidth'(1))} + {1'b0, step};
    endfunction

    logic [DataWidth-1:0] mem_q [NumWords];

    w_state_e             w_state_q, w_state_d;
    logic [IdWidth-1:0]   aw_id_q, aw_id_d;
    logic [AddrWidth-1:0] w_addr_q, w_addr_d;
    logic [7:0]           aw_len_q, aw_len_d, w_beat_q, w_beat_d;
    logic [2:0]           aw_size_q, aw_size_d;
    logic [1:0]           aw_burst_q, aw_burst_d;
    logic [5:0]           aw_atop_q, aw_atop_d;
    logic                 w_below_q, w_below_d, w_wrap_q, w_wrap_d, w_err_q, w_err_d;

    r_state_e             r_state_q, r_state_d;
    logic [IdWidth-1:0]   ar_id_q, ar_id_d;
    logic [AddrWidth-1:0] r_addr_q, r_addr_d;
    logic [7:0]           ar_len_q, ar_len_d, r_beat_q, r_beat_d;
    logic [2:0]           ar_size_q, ar_size_d;
    logic [1:0]           ar_burst_q, ar_burst_d;
    logic [3:0]           r_cnt_q, r_cnt_d;
    logic                 r_wrap_q, r_wrap_d, r_first_q, r_first_d;
    logic [DataWidth-1:0] r_data_q, r_data_d;

    // Keeps the address channels closed from reset until the first clock edge after release.
    logic                 live_q;

    logic aw_ready, w_ready, b_valid, ar_ready, r_valid, mem_we;
    logic w_abort, w_beat_ok, w_last_beat, r_beat_ok;
    logic [AddrWidth:0]   w_next, r_next;
    logic [IdxBits-1:0]   w_idx, r_idx;
    logic [DataWidth-1:0] rd_word;
    logic                 unused_req;

    assign unused_req  = ^axi_req_i;
    assign w_abort     = (aw_burst_q == BurstWrap) || (aw_atop_q != '0) || w_below_q;
    assign w_beat_ok   = !w_abort && !w_wrap_q && addr_ok(w_addr_q);
    assign w_last_beat = (w_beat_q == aw_len_q);
    assign w_next      = next_addr(w_addr_q, aw_size_q, aw_burst_q);
    assign w_idx       = word_idx(w_addr_q);
    assign r_beat_ok   = (ar_burst_q != BurstWrap) && !r_wrap_q && addr_ok(r_addr_q);
    assign r_next      = next_addr(r_addr_q, ar_size_q, ar_burst_q);
    assign r_idx       = word_idx(r_addr_q);
    assign rd_word     = r_beat_ok ? mem_q[r_idx] : '0;

    // Write engine: accept AW, commit beats, then hold B until accepted.
    always_comb begin
        w_state_d  = w_state_q;
        aw_id_d    = aw_id_q;
        w_addr_d   = w_addr_q;
        aw_len_d   = aw_len_q;
        aw_size_d  = aw_size_q;
        aw_burst_d = aw_burst_q;
        aw_atop_d  = aw_atop_q;
        w_beat_d   = w_beat_q;
        w_below_d  = w_below_q;
        w_wrap_d   = w_wrap_q;
        w_err_d    = w_err_q;
        aw_ready   = 1'b0;
        w_ready    = 1'b0;
        b_valid    = 1'b0;
        mem_we     = 1'b0;
        unique case (w_state_q)
            WIdle: begin
                aw_ready = live_q;
                if (live_q && axi_req_i.aw_valid) begin
                    aw_id_d    = axi_req_i.aw.id;
                    w_addr_d   = axi_req_i.aw.addr;
                    aw_len_d   = axi_req_i.aw.len;
                    aw_size_d  = axi_req_i.aw.size;
                    aw_burst_d = axi_req_i.aw.burst;
                    aw_atop_d  = axi_req_i.aw.atop;
                    w_below_d  = axi_req_i.aw.addr < MemBaseAddr;
                    w_beat_d   = '0;
                    w_wrap_d   = 1'b0;
                    w_err_d    = 1'b0;
                    w_state_d  = WData;
                end
            end
            WData: begin
                w_ready = 1'b1;
                if (axi_req_i.w_valid) begin
                    mem_we   = w_beat_ok;
                    w_addr_d = w_next[AddrWidth-1:0];
                    w_wrap_d = w_wrap_q | w_next[AddrWidth];
                    w_beat_d = w_beat_q + 8'd1;
                    if (!w_beat_ok || (axi_req_i.w.last != w_last_beat)) w_err_d = 1'b1;
                    if (axi_req_i.w.last || w_last_beat) w_state_d = WResp;
                end
            end
            WResp: begin
                b_valid = 1'b1;
                if (axi_req_i.b_ready) w_state_d = WIdle;
            end
            default: w_state_d = WIdle;
        endcase
    end

    // Read engine: accept AR, wait out the latency, then stream beats.
    always_comb begin
        r_state_d  = r_state_q;
        ar_id_d    = ar_id_q;
        r_addr_d   = r_addr_q;
        ar_len_d   = ar_len_q;
        ar_size_d  = ar_size_q;
        ar_burst_d = ar_burst_q;
        r_beat_d   = r_beat_q;
        r_cnt_d    = r_cnt_q;
        r_wrap_d   = r_wrap_q;
        r_first_d  = r_first_q;
        r_data_d   = r_data_q;
        ar_ready   = 1'b0;
        r_valid    = 1'b0;
        unique case (r_state_q)
            RIdle: begin
                ar_ready = live_q;
                if (live_q && axi_req_i.ar_valid) begin
                    ar_id_d    = axi_req_i.ar.id;
                    r_addr_d   = axi_req_i.ar.addr;
                    ar_len_d   = axi_req_i.ar.len;
                    ar_size_d  = axi_req_i.ar.size;
                    ar_burst_d = axi_req_i.ar.burst;
                    r_beat_d   = '0;
                    r_wrap_d   = 1'b0;
                    r_first_d  = 1'b1;
                    r_cnt_d    = 4'(ReadLatency);
                    r_state_d  = (ReadLatency == 0) ? RData : RWait;
                end
            end
            RWait: begin
                r_cnt_d = r_cnt_q - 4'd1;
                if (r_cnt_q <= 4'd1) r_state_d = RData;
            end
            RData: begin
                r_valid = 1'b1;
                // Snapshot the word in the beat's first cycle so the payload stays stable.
                if (r_first_q) r_data_d = rd_word;
                r_first_d = 1'b0;
                if (axi_req_i.r_ready) begin
                    if (r_beat_q == ar_len_q) begin
                        r_state_d = RIdle;
                    end else begin
                        r_beat_d  = r_beat_q + 8'd1;
                        r_addr_d  = r_next[AddrWidth-1:0];
                        r_wrap_d  = r_wrap_q | r_next[AddrWidth];
                        r_first_d = 1'b1;
                    end
                end
            end
            default: r_state_d = RIdle;
        endcase
    end

    // Response channel assembly; user fields stay zero.
    always_comb begin
        axi_rsp_o          = '0;
        axi_rsp_o.aw_ready = aw_ready;
        axi_rsp_o.w_ready  = w_ready;
        axi_rsp_o.ar_ready = ar_ready;
        axi_rsp_o.b_valid  = b_valid;
        axi_rsp_o.b.id     = aw_id_q;
        axi_rsp_o.b.resp   = w_err_q ? RespSlvErr : RespOkay;
        axi_rsp_o.r_valid  = r_valid;
        axi_rsp_o.r.id     = ar_id_q;
        axi_rsp_o.r.data   = r_first_q ? rd_word : r_data_q;
        axi_rsp_o.r.resp   = r_beat_ok ? RespOkay : RespSlvErr;
        axi_rsp_o.r.last   = (r_beat_q == ar_len_q);
    end

    // Control state; the memory array is deliberately left out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            live_q     <= 1'b0;
            w_state_q  <= WIdle;
            aw_id_q    <= '0;
            w_addr_q   <= '0;
            aw_len_q   <= '0;
            aw_size_q  <= '0;
            aw_burst_q <= '0;
            aw_atop_q  <= '0;
            w_beat_q   <= '0;
            w_below_q  <= 1'b0;
            w_wrap_q   <= 1'b0;
            w_err_q    <= 1'b0;
            r_state_q  <= RIdle;
            ar_id_q    <= '0;
            r_addr_q   <= '0;
            ar_len_q   <= '0;
            ar_size_q  <= '0;
            ar_burst_q <= '0;
            r_beat_q   <= '0;
            r_cnt_q    <= '0;
            r_wrap_q   <= 1'b0;
            r_first_q  <= 1'b0;
            r_data_q   <= '0;
        end else begin
            live_q     <= 1'b1;
            w_state_q  <= w_state_d;
            aw_id_q    <= aw_id_d;
            w_addr_q   <= w_addr_d;
            aw_len_q   <= aw_len_d;
            aw_size_q  <= aw_size_d;
            aw_burst_q <= aw_burst_d;
            aw_atop_q  <= aw_atop_d;
            w_beat_q   <= w_beat_d;
            w_below_q  <= w_below_d;
            w_wrap_q   <= w_wrap_d;
            w_err_q    <= w_err_d;
            r_state_q  <= r_state_d;
            ar_id_q    <= ar_id_d;
            r_addr_q   <= r_addr_d;
            ar_len_q   <= ar_len_d;
            ar_size_q  <= ar_size_d;
            ar_burst_q <= ar_burst_d;
            r_beat_q   <= r_beat_d;
            r_cnt_q    <= r_cnt_d;
            r_wrap_q   <= r_wrap_d;
            r_first_q  <= r_first_d;
            r_data_q   <= r_data_d;
        end
    end

    // Byte-lane memory write on each accepted in-range beat.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int unsigned b = 0; b < StrbWidth; b++) begin
                if (axi_req_i.w.strb[b]) mem_q[w_idx][8*b +: 8] <= axi_req_i.w.data[8*b +: 8];
            end
        end
    end

endmodule
